// File: rtl/chess_timer_core.sv
// Two-player chess clock timer: per-player seconds with private sub-second counters and flag fall.
// Define CHESS_TIMER_INCREMENT_EN to add INC_SEC to a player's time when their move completes.
module chess_timer_core #(
   parameter int CLK_HZ    = 10,
   parameter int START_SEC = 300,
   parameter int INC_SEC   = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        ta_i,
   input  logic        tb_i,
   input  logic        clr_i,
   output logic [15:0] time_a_o,
   output logic [15:0] time_b_o,
   output logic        flag_a_o,
   output logic        flag_b_o,
   output logic        game_over_o
);

   localparam int              SUB_W   = $clog2(CLK_HZ);
   localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(CLK_HZ - 1);
   localparam logic [15:0]     START_T = 16'(START_SEC);
   localparam logic [16:0]     INC_T   = 17'(INC_SEC);

   logic [SUB_W-1:0] sub_a_q, sub_a_d;
   logic [SUB_W-1:0] sub_b_q, sub_b_d;
   logic [15:0]      time_a_q, time_a_d;
   logic [15:0]      time_b_q, time_b_d;
   logic             flag_a_q, flag_a_d;
   logic             flag_b_q, flag_b_d;
   logic             game_over_q, game_over_d;

   logic run_a, run_b;
   logic tick_a, tick_b;
   logic dec_a, dec_b;
   logic inc_a, inc_b;

   // Ta=Tb=1 is illegal and pauses both sides, same as Ta=Tb=0.
   assign run_a  = ta_i & ~tb_i & ~clr_i & ~game_over_q;
   assign run_b  = tb_i & ~ta_i & ~clr_i & ~game_over_q;
   assign tick_a = run_a & (sub_a_q == SUB_MAX);
   assign tick_b = run_b & (sub_b_q == SUB_MAX);
   assign dec_a  = tick_a & (time_a_q != 16'd0);
   assign dec_b  = tick_b & (time_b_q != 16'd0);

`ifdef CHESS_TIMER_INCREMENT_EN
   logic ta_d_q;
   logic tb_d_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ta_d_q <= 1'b0;
         tb_d_q <= 1'b0;
      end else begin
         ta_d_q <= ta_i;
         tb_d_q <= tb_i;
      end
   end

   // A move completes on the falling edge of that player's run request.
   assign inc_a = ta_d_q & ~ta_i & ~clr_i & ~game_over_q;
   assign inc_b = tb_d_q & ~tb_i & ~clr_i & ~game_over_q;
`else
   assign inc_a = 1'b0;
   assign inc_b = 1'b0;
`endif

   function automatic logic [15:0] next_time(input logic [15:0] t,
                                             input logic        dec,
                                             input logic        inc);
      logic [16:0] sum;
      sum = {1'b0, t} - {16'd0, dec} + (inc ? INC_T : 17'd0);
      if (sum > 17'h0FFFF) begin
         return 16'hFFFF;
      end
      return sum[15:0];
   endfunction

   always_comb begin
      sub_a_d     = sub_a_q;
      sub_b_d     = sub_b_q;
      time_a_d    = time_a_q;
      time_b_d    = time_b_q;
      flag_a_d    = flag_a_q;
      flag_b_d    = flag_b_q;
      game_over_d = game_over_q;
      if (clr_i) begin
         sub_a_d     = '0;
         sub_b_d     = '0;
         time_a_d    = START_T;
         time_b_d    = START_T;
         flag_a_d    = 1'b0;
         flag_b_d    = 1'b0;
         game_over_d = 1'b0;
      end else begin
         if (run_a) begin
            sub_a_d = tick_a ? '0 : sub_a_q + 1'b1;
         end
         if (run_b) begin
            sub_b_d = tick_b ? '0 : sub_b_q + 1'b1;
         end
         time_a_d = next_time(time_a_q, dec_a, inc_a);
         time_b_d = next_time(time_b_q, dec_b, inc_b);
         if (dec_a && (time_a_d == 16'd0)) begin
            flag_a_d = 1'b1;
         end
         if (dec_b && (time_b_d == 16'd0)) begin
            flag_b_d = 1'b1;
         end
         game_over_d = game_over_q | flag_a_d | flag_b_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sub_a_q     <= '0;
         sub_b_q     <= '0;
         time_a_q    <= START_T;
         time_b_q    <= START_T;
         flag_a_q    <= 1'b0;
         flag_b_q    <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         sub_a_q     <= sub_a_d;
         sub_b_q     <= sub_b_d;
         time_a_q    <= time_a_d;
         time_b_q    <= time_b_d;
         flag_a_q    <= flag_a_d;
         flag_b_q    <= flag_b_d;
         game_over_q <= game_over_d;
      end
   end

   assign time_a_o    = time_a_q;
   assign time_b_o    = time_b_q;
   assign flag_a_o    = flag_a_q;
   assign flag_b_o    = flag_b_q;
   assign game_over_o = game_over_q;

endmodule

// File: tb/tb_chess_timer_core.sv
// Bench for chess_timer_core: elapsed-edge reference model checked every cycle, plus directed literal checks.
module tb_chess_timer_core;

   localparam int CLK_HZ    = 10;
   localparam int START_SEC = 3;
   localparam int INC_SEC   = 2;
`ifdef CHESS_TIMER_INCREMENT_EN
   localparam int BON = INC_SEC;
`else
   localparam int BON = 0;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        ta    = 1'b0;
   logic        tb    = 1'b0;
   logic        clr   = 1'b0;
   logic [15:0] time_a;
   logic [15:0] time_b;
   logic        flag_a;
   logic        flag_b;
   logic        game_over;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   chess_timer_core #(
      .CLK_HZ   (CLK_HZ),
      .START_SEC(START_SEC),
      .INC_SEC  (INC_SEC)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .ta_i       (ta),
      .tb_i       (tb),
      .clr_i      (clr),
      .time_a_o   (time_a),
      .time_b_o   (time_b),
      .flag_a_o   (flag_a),
      .flag_b_o   (flag_b),
      .game_over_o(game_over)
   );

   // Model: each player's clock is described by the number of edges it has
   // run since the last reload plus the bonus seconds earned by moves.
   int ea = 0, eb = 0, ba = 0, bb = 0;
   bit pa = 1'b0, pb = 1'b0;

   function automatic int secs(input int e, input int b);
      int s;
      s = START_SEC + b - e / CLK_HZ;
      return (s > 65535) ? 65535 : s;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit go;
      if (!rst_n) begin
         ea = 0; eb = 0; ba = 0; bb = 0; pa = 1'b0; pb = 1'b0;
      end else begin
         go = (secs(ea, ba) == 0) || (secs(eb, bb) == 0);
         if (clr) begin
            ea = 0; eb = 0; ba = 0; bb = 0;
         end else if (!go) begin
            if (ta && !tb) ea++;
            if (tb && !ta) eb++;
`ifdef CHESS_TIMER_INCREMENT_EN
            if (pa && !ta) ba += INC_SEC;
            if (pb && !tb) bb += INC_SEC;
`endif
         end
         pa = ta;
         pb = tb;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      int sa, sb;
      sa = secs(ea, ba);
      sb = secs(eb, bb);
      chk("model_time_a", int'(time_a), sa);
      chk("model_time_b", int'(time_b), sb);
      chk("model_flag_a", int'(flag_a), int'(sa == 0));
      chk("model_flag_b", int'(flag_b), int'(sb == 0));
      chk("model_game_over", int'(game_over), int'((sa == 0) || (sb == 0)));
   end

   task automatic cyc(input logic a, input logic b, input logic c, input int n);
      repeat (n) begin
         ta  = a;
         tb  = b;
         clr = c;
         @(posedge clk);
         #1;
      end
      ta  = 1'b0;
      tb  = 1'b0;
      clr = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int r, len;
      logic a, b;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_time_a", int'(time_a), 3);
      chk("rst_time_b", int'(time_b), 3);
      chk("rst_flag_a", int'(flag_a), 0);
      chk("rst_flag_b", int'(flag_b), 0);
      chk("rst_game_over", int'(game_over), 0);

      cyc(1, 0, 0, 10);
      chk("a10_time_a", int'(time_a), 2);
      chk("a10_time_b", int'(time_b), 3);

      cyc(0, 0, 1, 1);
      cyc(1, 0, 0, 5);
      cyc(0, 1, 0, 10);
      chk("b10_time_b", int'(time_b), 2);
      cyc(1, 0, 0, 4);
      chk("partial_time_a9", int'(time_a), 3 + BON);
      cyc(1, 0, 0, 1);
      chk("partial_time_a10", int'(time_a), 2 + BON);
      chk("partial_time_b", int'(time_b), 2 + BON);

      cyc(0, 0, 1, 1);
      cyc(1, 0, 0, 29);
      chk("a29_time_a", int'(time_a), 1);
      chk("a29_game_over", int'(game_over), 0);
      cyc(1, 0, 0, 1);
      chk("flagfall_time_a", int'(time_a), 0);
      chk("flagfall_flag_a", int'(flag_a), 1);
      chk("flagfall_game_over", int'(game_over), 1);
      cyc(0, 1, 0, 20);
      chk("frozen_time_b", int'(time_b), 3);
      chk("frozen_time_a", int'(time_a), 0);
      cyc(0, 0, 1, 1);
      chk("clr_time_a", int'(time_a), 3);
      chk("clr_time_b", int'(time_b), 3);
      chk("clr_flag_a", int'(flag_a), 0);
      chk("clr_game_over", int'(game_over), 0);

      cyc(1, 1, 0, 20);
      chk("both_time_a", int'(time_a), 3);
      chk("both_time_b", int'(time_b), 3);
      cyc(1, 0, 0, 9);
      cyc(1, 0, 1, 1);
      chk("clr_on_tick_time_a", int'(time_a), 3);
      cyc(1, 0, 0, 9);
      chk("clr_sub_reset9", int'(time_a), 3);
      cyc(1, 0, 0, 1);
      chk("clr_sub_reset10", int'(time_a), 2);

      cyc(0, 0, 1, 1);
      cyc(1, 0, 0, 7);
      pulse_reset();
      cyc(1, 0, 0, 9);
      chk("rst_mid_a9", int'(time_a), 3);
      cyc(1, 0, 0, 1);
      chk("rst_mid_a10", int'(time_a), 2);

      cyc(0, 0, 1, 1);
      cyc(1, 0, 0, 10);
      cyc(0, 1, 0, 1);
      chk("move_inc_time_a", int'(time_a), 2 + BON);

      for (int i = 0; i < 500; i++) begin
         r   = $urandom_range(0, 99);
         len = $urandom_range(1, 15);
         a   = (r < 45) || (r >= 90 && r < 95);
         b   = (r >= 45 && r < 95);
         if ($urandom_range(0, 7) == 0) begin
            cyc(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), 1'b1, 1);
         end
         cyc(a, b, 1'b0, len);
         if ($urandom_range(0, 79) == 0) begin
            pulse_reset();
         end
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/chess_timer_core.md
CHESS_TIMER_CORE -- requirements
Module: chess_timer_core

Interface
REQ-001 Parameter CLK_HZ, 10, clock cycles per second; legal range 2..65535.
REQ-002 Parameter START_SEC, 300, seconds loaded into each player's time on reset or Clr; legal range 1..65535.
REQ-003 Parameter INC_SEC, 2, seconds added per completed move; used only when INCREMENT_EN is defined.
REQ-004 clock  input  1  system clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 Ta  input  1  player A's timer runs; driven by the chess clock FSM.
REQ-007 Tb  input  1  player B's timer runs; driven by the chess clock FSM.
REQ-008 Clr  input  1  synchronous reload of both timers; active-high.
REQ-009 time_a  output  16  player A's remaining seconds; registered.
REQ-010 time_b  output  16  player B's remaining seconds; registered.
REQ-011 flag_a / flag_b  output  1 each  player's time has reached 0 (flag fall); registered.
REQ-012 game_over  output  1  flag_a OR flag_b; registered.

Function
REQ-013 Each player SHALL have a private sub-second counter (0..CLK_HZ-1) that holds its value while that player's timer is paused.
REQ-014 Player A counts on an edge when Ta=1, Tb=0, Clr=0 and game_over=0; player B counts under the mirrored condition.
REQ-015 On a counting edge: if the sub-counter < CLK_HZ-1, increment it; otherwise set it to 0 and decrement that player's time by 1 on the same edge.
REQ-016 When a decrement takes a time from 1 to 0, set that player's flag and game_over on the same edge; time SHALL NOT underflow below 0.
REQ-017 While game_over=1, neither time nor sub-counter SHALL change until Clr or reset; Ta/Tb are ignored.
REQ-018 Ta=Tb=1 SHALL be treated as illegal: neither player counts and all state holds.
REQ-019 Ta=Tb=0 SHALL hold all state (clock paused).
REQ-020 Clr=1 SHALL have priority over counting and increment on the same edge: both times <= START_SEC, both sub-counters <= 0, flags <= 0, game_over <= 0.
REQ-021 Output latency: a tick edge updates time_x and flag_x at that edge; there is no extra pipeline stage.

Reset
REQ-022 reset low SHALL asynchronously force time_a = time_b = START_SEC, sub-counters = 0, flag_a = flag_b = game_over = 0, and the Ta/Tb history registers = 0.
REQ-023 Reset asserted mid-count SHALL discard any partial second; counting resumes from sub-counter 0 on the first qualifying edge after release.

Configuration
REQ-024 Macro CHESS_TIMER_INCREMENT_EN defined: register Ta/Tb delayed by one edge; on an edge where Ta_d=1, Ta=0, Clr=0 and game_over=0, time_a SHALL be incremented by INC_SEC, saturating at 16'hFFFF (mirrored for B).
REQ-025 If a tick decrement and an increment coincide for the same player, the result SHALL be time - 1 + INC_SEC, saturated.
REQ-026 Macro undefined: no history registers exist, and a move completion leaves time unchanged.

Verification (CLK_HZ=10, START_SEC=3, INC_SEC=2)
REQ-027 reset low for 2 cycles, then high -> time_a=3, time_b=3, all flags 0.
REQ-028 Ta=1, Tb=0 for 10 edges -> time_a=2 after the 10th edge; time_b=3.
REQ-029 Ta for 5 edges, then Tb for 10 edges, then Ta for 5 edges -> time_b=2, and time_a=2 exactly after the final A edge (partial second retained).
REQ-030 Ta held 30 edges -> time_a=0 with flag_a=1 and game_over=1 on the 30th edge; a following 20 edges of Tb=1 leaves time_b=3; then Clr pulse -> time_a=time_b=3 and flags 0.
REQ-031 Ta=Tb=1 for 20 edges -> no state change; Clr asserted on an A tick edge -> reload wins (time_a=3).
REQ-032 With CHESS_TIMER_INCREMENT_EN: Ta 10 edges then Ta=0/Tb=1 -> time_a=4 (2+2); without the macro -> time_a=2.
